// File: rtl/riscv_issue_pkg.sv
// Shared opcode-class constants, instruction field slices and the issue-slot record
// used by the riscv_issue stage.
package riscv_issue_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } iss_slot_t;

   function automatic logic [6:0] f_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] instr);
      return instr[11:7];
   endfunction

   function automatic logic [4:0] f_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] f_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   function automatic logic f_writes_rd(input logic [6:0] opc);
      logic w_hit;
      case (opc)
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: w_hit = 1'b1;
         default:                                                  w_hit = 1'b0;
      endcase
      return w_hit;
   endfunction

   // Branches are legal but never write rd, so they sit outside f_writes_rd.
   function automatic logic f_known(input logic [6:0] opc);
      return f_writes_rd(opc) | (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/riscv_issue_regfile.sv
// Architectural register file: x1..x31 storage, two asynchronous read ports,
// one synchronous write port, x0 reads as zero.
module riscv_issue_regfile #(
   parameter bit ZERO_INIT = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_ra_idx,
   input  logic [4:0]  i_rb_idx,
   output logic [31:0] o_ra_data,
   output logic [31:0] o_rb_data,
   input  logic        i_we,
   input  logic [4:0]  i_wr_idx,
   input  logic [31:0] i_wr_data
);

   logic [31:0] r_regs [1:31];
   logic        w_wr_en;

   assign w_wr_en = i_we & (i_wr_idx != 5'd0);

   generate
      if (ZERO_INIT) begin : g_rst
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               for (int i = 1; i < 32; i++) r_regs[i] <= '0;
            end else if (w_wr_en) begin
               r_regs[i_wr_idx] <= i_wr_data;
            end
         end
      end else begin : g_norst
         // Storage is left unreset; writes are still blocked while reset is held.
         always_ff @(posedge i_clk) begin
            if (w_wr_en && !i_rst) r_regs[i_wr_idx] <= i_wr_data;
         end
      end
   endgenerate

   assign o_ra_data = (i_ra_idx == 5'd0) ? 32'd0 : r_regs[i_ra_idx];
   assign o_rb_data = (i_rb_idx == 5'd0) ? 32'd0 : r_regs[i_rb_idx];

endmodule

// File: rtl/riscv_issue.sv
// Single-issue, in-order issue stage feeding riscv_exec: one issue register,
// register-file read with writeback bypass, taken-branch squash and rd writeback.
module riscv_issue
   import riscv_issue_pkg::*;
#(
   parameter bit REGFILE_ZERO_INIT = 1'b1,
   parameter bit SUPPORT_BYPASS    = 1'b1
) (
   input  logic        InClk,
   input  logic        InRst,
   input  logic        InFetchValid,
   input  logic [31:0] InFetchInstr,
   input  logic [31:0] InFetchPc,
   input  logic        InFetchFault,
   output logic        OutFetchAccept,
   input  logic        InHold,
   input  logic        InBranchIsTaken,
   input  logic [31:0] InExecWbValue,
   output logic        OutOpcodeValid,
   output logic [31:0] OutOpcodeOpcode,
   output logic [31:0] OutOpcodePc,
   output logic        OutOpcodeInvalid,
   output logic [4:0]  OutOpcodeRdIdx,
   output logic [4:0]  OutOpcodeRaIdx,
   output logic [4:0]  OutOpcodeRbIdx,
   output logic [31:0] OutOpcodeRaOperand,
   output logic [31:0] OutOpcodeRbOperand
);

   iss_slot_t   r_iss;
   logic        r_chk;
   logic        r_wb_valid;
   logic [4:0]  r_wb_rd;

   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_ra, w_rb;
   logic [31:0] w_ra_rf, w_rb_rf;
   logic        w_squash, w_ra_hit, w_rb_hit, w_raw_stall;
   logic        w_accept, w_opc_valid, w_invalid, w_wb_next;

   assign w_opc = f_opcode(r_iss.instr);
   assign w_rd  = f_rd(r_iss.instr);
   assign w_ra  = f_rs1(r_iss.instr);
   assign w_rb  = f_rs2(r_iss.instr);

   // Only the slot directly behind an issued instruction can be wrong-path.
   assign w_squash = r_chk & InBranchIsTaken;

   // r_wb_rd is never 0 while r_wb_valid is set, so x0 can never hit.
   assign w_ra_hit    = r_wb_valid & (r_wb_rd == w_ra);
   assign w_rb_hit    = r_wb_valid & (r_wb_rd == w_rb);
   assign w_raw_stall = ~SUPPORT_BYPASS & r_iss.valid & ~w_squash & (w_ra_hit | w_rb_hit);

   // Handshake: fetch's word is transferred on any cycle with InFetchValid and
   // OutFetchAccept both high; with InFetchValid low the accept loads a bubble.
   assign w_accept    = ~InHold & ~InRst & ~w_raw_stall;
   assign w_opc_valid = r_iss.valid & ~InHold & ~w_squash & ~w_raw_stall;
   assign w_invalid   = r_iss.valid & (r_iss.fault | ~f_known(w_opc));
   assign w_wb_next   = w_opc_valid & f_writes_rd(w_opc) & ~w_invalid & (w_rd != 5'd0);

   riscv_issue_regfile #(
      .ZERO_INIT (REGFILE_ZERO_INIT)
   ) u_regfile (
      .i_clk     (InClk),
      .i_rst     (InRst),
      .i_ra_idx  (w_ra),
      .i_rb_idx  (w_rb),
      .o_ra_data (w_ra_rf),
      .o_rb_data (w_rb_rf),
      .i_we      (r_wb_valid),
      .i_wr_idx  (r_wb_rd),
      .i_wr_data (InExecWbValue)
   );

   always_ff @(posedge InClk or posedge InRst) begin
      if (InRst) begin
         r_iss      <= '0;
         r_chk      <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
      end else begin
         if (w_accept) begin
            r_iss.valid <= InFetchValid & ~w_squash;
            r_iss.instr <= InFetchInstr;
            r_iss.pc    <= InFetchPc;
            r_iss.fault <= InFetchFault;
         end
         r_chk      <= w_opc_valid;
         r_wb_valid <= w_wb_next;
         r_wb_rd    <= w_rd;
      end
   end

   assign OutFetchAccept     = w_accept;
   assign OutOpcodeValid     = w_opc_valid;
   assign OutOpcodeOpcode    = r_iss.instr;
   assign OutOpcodePc        = r_iss.pc;
   assign OutOpcodeInvalid   = w_invalid;
   assign OutOpcodeRdIdx     = w_rd;
   assign OutOpcodeRaIdx     = w_ra;
   assign OutOpcodeRbIdx     = w_rb;
   assign OutOpcodeRaOperand = (SUPPORT_BYPASS && w_ra_hit) ? InExecWbValue : w_ra_rf;
   assign OutOpcodeRbOperand = (SUPPORT_BYPASS && w_rb_hit) ? InExecWbValue : w_rb_rf;

endmodule
